// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares the single core-side port of memory_controller between two bus
// masters (m0 = core, m1 = debug/DMA). Arbitration is round-robin. The winning
// request is registered at the grant edge, and every downstream s_* output is
// driven from those registers. The arbiter follows the downstream busy
// handshake and returns a one-cycle ack with registered read data. A timeout
// in ISSUE forces an error completion if the downstream never raises busy.
//
// Ports
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   mX_rd_en, mX_wr_en      : master X request enables (rd+wr together = write)
//   mX_byte_en              : master X byte lanes
//   mX_addr, mX_wr_data     : master X address and write data
//   mX_rd_data              : read data, held until master X's next ack
//   mX_ack                  : one-cycle completion pulse for master X
//   mX_err                  : timeout flag, valid with mX_ack
//   s_rd_en, s_wr_en        : downstream enables
//   s_byte_en               : downstream byte lanes
//   s_addr, s_wr_data       : downstream address and write data
//   s_rd_data, s_busy       : downstream response
//   grant                   : one-hot current owner, 0 when the bus is free
module mem_bus_arbiter #(
  parameter int BYTE_AMNT = 4,
  parameter int DATA_SIZE = 8 * BYTE_AMNT,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 m0_rd_en,
  input  logic                 m0_wr_en,
  input  logic [BYTE_AMNT-1:0] m0_byte_en,
  input  logic [DATA_SIZE-1:0] m0_addr,
  input  logic [DATA_SIZE-1:0] m0_wr_data,
  output logic [DATA_SIZE-1:0] m0_rd_data,
  output logic                 m0_ack,
  output logic                 m0_err,
  input  logic                 m1_rd_en,
  input  logic                 m1_wr_en,
  input  logic [BYTE_AMNT-1:0] m1_byte_en,
  input  logic [DATA_SIZE-1:0] m1_addr,
  input  logic [DATA_SIZE-1:0] m1_wr_data,
  output logic [DATA_SIZE-1:0] m1_rd_data,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic                 s_rd_en,
  output logic                 s_wr_en,
  output logic [BYTE_AMNT-1:0] s_byte_en,
  output logic [DATA_SIZE-1:0] s_addr,
  output logic [DATA_SIZE-1:0] s_wr_data,
  input  logic [DATA_SIZE-1:0] s_rd_data,
  input  logic                 s_busy,
  output logic [1:0]           grant
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  logic [2:0] state;
  // Index of the most recently granted master. During HOLD it is also the
  // master that was just served, so it doubles as the HOLD mask.
  logic       last_grant;
  logic [7:0] tmo_cnt;

  logic                 cand0;
  logic                 cand1;
  logic                 arb_valid;
  logic                 arb_sel;
  logic                 sel_rd;
  logic                 sel_wr;
  logic [BYTE_AMNT-1:0] sel_be;
  logic [DATA_SIZE-1:0] sel_addr;
  logic [DATA_SIZE-1:0] sel_wdata;

  logic                 done_ok;
  logic                 done_tmo;
  logic                 done;
  logic [DATA_SIZE-1:0] resp_data;

  // Arbitration runs in IDLE and HOLD only. In HOLD the master just served
  // is masked, because it may still be holding its enables for one cycle.
  always_comb begin
    cand0     = (m0_rd_en | m0_wr_en) && !(state == ST_HOLD && !last_grant);
    cand1     = (m1_rd_en | m1_wr_en) && !(state == ST_HOLD && last_grant);
    arb_valid = (state == ST_IDLE || state == ST_HOLD) && (cand0 || cand1);
    // On a tie the master that did not win last time is chosen.
    arb_sel   = (cand0 && cand1) ? ~last_grant : cand1;

    sel_rd    = arb_sel ? m1_rd_en   : m0_rd_en;
    sel_wr    = arb_sel ? m1_wr_en   : m0_wr_en;
    sel_be    = arb_sel ? m1_byte_en : m0_byte_en;
    sel_addr  = arb_sel ? m1_addr    : m0_addr;
    sel_wdata = arb_sel ? m1_wr_data : m0_wr_data;
  end

  // Completion: normal when busy has come and gone, error when ISSUE has
  // waited TIMEOUT cycles with no busy. Busy seen on the limit cycle wins.
  always_comb begin
    done_ok   = (state == ST_WAIT) && !s_busy;
    done_tmo  = (state == ST_ISSUE) && !s_busy && (tmo_cnt == TMO_LIMIT);
    done      = done_ok | done_tmo;
    resp_data = (done_ok && s_rd_en) ? s_rd_data : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      last_grant <= 1'b1;
      tmo_cnt    <= 8'd0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      s_rd_en    <= 1'b0;
      s_wr_en    <= 1'b0;
      s_byte_en  <= '0;
      s_addr     <= '0;
      s_wr_data  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;

      if (arb_valid) begin
        state      <= ST_ISSUE;
        grant      <= arb_sel ? 2'b10 : 2'b01;
        last_grant <= arb_sel;
        tmo_cnt    <= 8'd0;
        s_rd_en    <= sel_rd & ~sel_wr;
        s_wr_en    <= sel_wr;
        s_byte_en  <= sel_be;
        s_addr     <= sel_addr;
        s_wr_data  <= sel_wdata;
      end else if (done) begin
        state     <= ST_ACK;
        s_rd_en   <= 1'b0;
        s_wr_en   <= 1'b0;
        s_byte_en <= '0;
        m0_ack    <= grant[0];
        m1_ack    <= grant[1];
        m0_err    <= grant[0] & done_tmo;
        m1_err    <= grant[1] & done_tmo;
      end else begin
        case (state)
          ST_ISSUE: begin
            if (s_busy) begin
              state <= ST_WAIT;
            end else if (tmo_cnt != 8'hFF) begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          ST_WAIT: begin
          end
          ST_ACK: begin
            state <= ST_HOLD;
            grant <= 2'b00;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Read data returns only to the master that owns the completing
  // transaction. The other master's value is left untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m0_rd_data <= '0;
      m1_rd_data <= '0;
    end else if (done) begin
      if (grant[0]) m0_rd_data <= resp_data;
      if (grant[1]) m1_rd_data <= resp_data;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed master traffic, a reactive
// downstream stub, and a transaction-level reference model compared against
// the DUT outputs every cycle.
module tb_mem_bus_arbiter;

  localparam int BA  = 4;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic          m0_rd_en = 1'b0, m0_wr_en = 1'b0;
  logic [BA-1:0] m0_byte_en = '0;
  logic [DW-1:0] m0_addr = '0, m0_wr_data = '0;
  logic [DW-1:0] m0_rd_data;
  logic          m0_ack, m0_err;
  logic          m1_rd_en = 1'b0, m1_wr_en = 1'b0;
  logic [BA-1:0] m1_byte_en = '0;
  logic [DW-1:0] m1_addr = '0, m1_wr_data = '0;
  logic [DW-1:0] m1_rd_data;
  logic          m1_ack, m1_err;
  logic          s_rd_en, s_wr_en;
  logic [BA-1:0] s_byte_en;
  logic [DW-1:0] s_addr, s_wr_data;
  logic [DW-1:0] s_rd_data = '0;
  logic          s_busy = 1'b0;
  logic [1:0]    grant;

  mem_bus_arbiter #(.BYTE_AMNT(BA), .DATA_SIZE(DW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_byte_en(m0_byte_en),
    .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_rd_data(m0_rd_data),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_byte_en(m1_byte_en),
    .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_rd_data(m1_rd_data),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_byte_en(s_byte_en),
    .s_addr(s_addr), .s_wr_data(s_wr_data), .s_rd_data(s_rd_data),
    .s_busy(s_busy), .grant(grant)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [BA-1:0] be;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  function automatic req_t mk(input logic rd, input logic wr, input logic [BA-1:0] be,
                              input logic [DW-1:0] addr, input logic [DW-1:0] data);
    req_t r;
    r.rd = rd; r.wr = wr; r.be = be; r.addr = addr; r.data = data;
    return r;
  endfunction

  req_t q0[$];
  req_t q1[$];
  req_t cur0, cur1;
  bit   act0 = 1'b0, act1 = 1'b0;

  // downstream stub controls
  int            stub_dly   = 1;
  int            stub_len   = 1;
  bit            stub_never = 1'b0;
  logic [DW-1:0] stub_rdata = '0;
  int            en_cyc     = 0;

  // reference model state: who owns the bus and how far its transaction is
  int            own      = -1;
  int            masked   = -1;
  int            last     = 1;
  int            age      = 0;
  bit            saw_busy = 1'b0;
  bit            acking   = 1'b0;
  logic [1:0]    e_grant  = '0;
  logic          e_s_rd = 1'b0, e_s_wr = 1'b0;
  logic [BA-1:0] e_s_be = '0;
  logic [DW-1:0] e_s_addr = '0, e_s_wd = '0;
  logic          e_ack [2];
  logic          e_err [2];
  logic [DW-1:0] e_rdata [2];

  bit         cmp_on = 1'b0;
  logic [1:0] gseq[$];
  logic [1:0] gprev = '0;

  task automatic mdl_reset();
    own = -1; masked = -1; last = 1; age = 0; saw_busy = 0; acking = 0;
    e_grant = '0; e_s_rd = 0; e_s_wr = 0; e_s_be = '0; e_s_addr = '0; e_s_wd = '0;
    for (int m = 0; m < 2; m++) begin
      e_ack[m] = 0; e_err[m] = 0; e_rdata[m] = '0;
    end
  endtask

  task automatic mdl_finish(input bit tmo, input logic [DW-1:0] data);
    e_ack[own] = 1'b1;
    e_err[own] = tmo;
    e_rdata[own] = data;
    e_s_rd = 0; e_s_wr = 0; e_s_be = '0;
    acking = 1'b1;
  endtask

  // One clock of the transaction-level rules, using pre-edge inputs.
  task automatic mdl_step();
    bit r0, r1;
    int pick;
    e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
    if (acking) begin
      acking = 0;
      masked = own;
      own = -1;
      e_grant = '0;
    end else if (own >= 0) begin
      if (!saw_busy) begin
        if (s_busy) saw_busy = 1'b1;
        else if (age == TMO) mdl_finish(1'b1, '0);
        else age++;
      end else if (!s_busy) begin
        mdl_finish(1'b0, e_s_rd ? s_rd_data : '0);
      end
    end else begin
      r0 = (m0_rd_en | m0_wr_en) && (masked != 0);
      r1 = (m1_rd_en | m1_wr_en) && (masked != 1);
      masked = -1;
      pick = -1;
      if (r0 && r1) pick = 1 - last;
      else if (r0)  pick = 0;
      else if (r1)  pick = 1;
      if (pick >= 0) begin
        own = pick; last = pick; age = 0; saw_busy = 0;
        e_grant = (pick == 0) ? 2'b01 : 2'b10;
        if (pick == 0) begin
          e_s_wr = m0_wr_en; e_s_rd = m0_rd_en & ~m0_wr_en;
          e_s_be = m0_byte_en; e_s_addr = m0_addr; e_s_wd = m0_wr_data;
        end else begin
          e_s_wr = m1_wr_en; e_s_rd = m1_rd_en & ~m1_wr_en;
          e_s_be = m1_byte_en; e_s_addr = m1_addr; e_s_wd = m1_wr_data;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int acks, span, seen, t_ack, t_g1;

    mdl_reset();
    fork
      // reference model
      forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) mdl_reset();
        else mdl_step();
      end
      // master drivers: present queue heads, pop on ack, re-request at once
      forever begin
        @(negedge clock);
        if (!reset_n) begin
          q0.delete(); q1.delete(); act0 = 0; act1 = 0;
        end else begin
          if (act0 && m0_ack) act0 = 0;
          if (!act0 && q0.size() > 0) begin cur0 = q0.pop_front(); act0 = 1; end
          if (act1 && m1_ack) act1 = 0;
          if (!act1 && q1.size() > 0) begin cur1 = q1.pop_front(); act1 = 1; end
        end
        m0_rd_en   = act0 & cur0.rd;
        m0_wr_en   = act0 & cur0.wr;
        m0_byte_en = act0 ? cur0.be   : '0;
        m0_addr    = act0 ? cur0.addr : '0;
        m0_wr_data = act0 ? cur0.data : '0;
        m1_rd_en   = act1 & cur1.rd;
        m1_wr_en   = act1 & cur1.wr;
        m1_byte_en = act1 ? cur1.be   : '0;
        m1_addr    = act1 ? cur1.addr : '0;
        m1_wr_data = act1 ? cur1.data : '0;
      end
      // downstream stub: busy for stub_len cycles after stub_dly enable cycles
      forever begin
        @(negedge clock);
        if (s_rd_en | s_wr_en) begin
          en_cyc++;
          s_busy = !stub_never && (en_cyc > stub_dly) && (en_cyc <= stub_dly + stub_len);
        end else begin
          en_cyc = 0;
          s_busy = 1'b0;
        end
        s_rd_data = stub_rdata;
      end
      // per-cycle comparison against the model
      forever begin
        @(negedge clock);
        if (cmp_on) begin
          chk("cmp_grant", grant, e_grant);
          chk("cmp_s_rd_en", s_rd_en, e_s_rd);
          chk("cmp_s_wr_en", s_wr_en, e_s_wr);
          chk("cmp_s_byte_en", s_byte_en, e_s_be);
          chk("cmp_s_addr", s_addr, e_s_addr);
          chk("cmp_s_wr_data", s_wr_data, e_s_wd);
          chk("cmp_m0_ack", m0_ack, e_ack[0]);
          chk("cmp_m0_err", m0_err, e_err[0]);
          chk("cmp_m0_rd_data", m0_rd_data, e_rdata[0]);
          chk("cmp_m1_ack", m1_ack, e_ack[1]);
          chk("cmp_m1_err", m1_err, e_err[1]);
          chk("cmp_m1_rd_data", m1_rd_data, e_rdata[1]);
        end
      end
      // record the order of grants
      forever begin
        @(negedge clock);
        if (grant != 2'b00 && gprev == 2'b00) gseq.push_back(grant);
        gprev = grant;
      end
    join_none

    // reset state
    #1 reset_n = 1'b0;
    cmp_on = 1'b1;
    run_cycles(3);
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_en", {s_rd_en, s_wr_en}, 2'b00);
    chk("rst_s_byte_en", s_byte_en, 4'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'h0);
    chk("rst_rd_data", {m0_rd_data, m1_rd_data}, 64'h0);
    reset_n = 1'b1;
    run_cycles(2);

    // single read from m0, busy for 2 cycles
    stub_dly = 1; stub_len = 2; stub_never = 0; stub_rdata = 32'hDEADBEEF;
    q0.push_back(mk(1, 0, 4'hF, 32'h100, 32'h0));
    acks = 0; span = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (s_rd_en) begin span++; chk("t1_addr", s_addr, 32'h100); end
      if (m0_ack) begin
        acks++;
        chk("t1_rdata", m0_rd_data, 32'hDEADBEEF);
        chk("t1_err", m0_err, 1'b0);
      end
    end
    chk("t1_acks", acks, 1);
    chk("t1_span", span, 4);

    // single write from m1
    stub_dly = 0; stub_len = 1; stub_rdata = 32'hA5A5A5A5;
    q1.push_back(mk(0, 1, 4'h3, 32'h2004, 32'h12345678));
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (s_rd_en | s_wr_en) begin
        chk("t2_wr_en", s_wr_en, 1'b1);
        chk("t2_rd_en", s_rd_en, 1'b0);
        chk("t2_be", s_byte_en, 4'h3);
        chk("t2_wdata", s_wr_data, 32'h12345678);
      end
      if (m1_ack) acks++;
    end
    chk("t2_acks", acks, 1);
    chk("t2_m1_rdata", m1_rd_data, 32'h0);
    chk("t2_m0_rdata_kept", m0_rd_data, 32'hDEADBEEF);

    // rd+wr together is a write and returns 0 as read data
    q0.push_back(mk(1, 1, 4'hF, 32'h40, 32'h55AA55AA));
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (s_wr_en) chk("t2b_rd_en", s_rd_en, 1'b0);
    end
    chk("t2b_m0_rdata", m0_rd_data, 32'h0);

    // tie right after reset: m0 first, m1 granted out of HOLD
    @(negedge clock); reset_n = 1'b0;
    run_cycles(2);
    reset_n = 1'b1;
    gseq.delete();
    stub_rdata = 32'h0BADF00D;
    q0.push_back(mk(1, 0, 4'hF, 32'h800, 32'h0));
    q1.push_back(mk(1, 0, 4'hF, 32'h900, 32'h0));
    t_ack = -1; t_g1 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (m0_ack && t_ack < 0) t_ack = i;
      if (grant == 2'b10 && t_g1 < 0) t_g1 = i;
    end
    chk("t3_ngrants", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("t3_first", gseq[0], 2'b01);
      chk("t3_second", gseq[1], 2'b10);
    end
    chk("t3_hold_gap", t_g1 - t_ack, 2);

    // fairness: alternating grants with m0 re-requesting immediately
    gseq.delete();
    stub_rdata = 32'h11112222;
    q0.push_back(mk(1, 0, 4'hF, 32'h10, 32'h0));
    q0.push_back(mk(1, 0, 4'hF, 32'h14, 32'h0));
    q1.push_back(mk(1, 0, 4'hF, 32'h20, 32'h0));
    q1.push_back(mk(1, 0, 4'hF, 32'h24, 32'h0));
    run_cycles(40);
    chk("t4_ngrants", gseq.size(), 4);
    if (gseq.size() == 4) begin
      chk("t4_g0", gseq[0], 2'b01);
      chk("t4_g1", gseq[1], 2'b10);
      chk("t4_g2", gseq[2], 2'b01);
      chk("t4_g3", gseq[3], 2'b10);
    end
    chk("t4_m0_rdata", m0_rd_data, 32'h11112222);

    // timeout: downstream never raises busy
    stub_never = 1;
    q0.push_back(mk(1, 0, 4'hF, 32'h300, 32'h0));
    acks = 0; span = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (s_rd_en) span++;
      if (m0_ack) begin
        acks++;
        chk("t5_err", m0_err, 1'b1);
        chk("t5_rdata", m0_rd_data, 32'h0);
        chk("t5_en_drop", {s_rd_en, s_wr_en}, 2'b00);
      end
    end
    chk("t5_acks", acks, 1);
    chk("t5_issue_cycles", span, 16);
    stub_never = 0;

    // reset asserted while busy is high in WAIT
    stub_dly = 0; stub_len = 50;
    q1.push_back(mk(1, 0, 4'hF, 32'h400, 32'h0));
    seen = 0;
    for (int i = 0; i < 10 && seen < 2; i++) begin
      @(negedge clock); #1;
      if (s_busy && s_rd_en) seen++;
    end
    chk("t6_reached_wait", seen, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_grant", grant, 2'b00);
    chk("t6_s_en", {s_rd_en, s_wr_en}, 2'b00);
    chk("t6_s_addr", s_addr, 32'h0);
    chk("t6_rd_data", {m0_rd_data, m1_rd_data}, 64'h0);
    chk("t6_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'h0);
    acks = 0;
    run_cycles(2);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (m0_ack | m1_ack) acks++;
    end
    chk("t6_no_ack", acks, 0);
    stub_dly = 1; stub_len = 1; stub_rdata = 32'hCAFEF00D;
    q0.push_back(mk(1, 0, 4'hF, 32'h500, 32'h0));
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (m0_ack) begin
        acks++;
        chk("t6_new_rdata", m0_rd_data, 32'hCAFEF00D);
      end
    end
    chk("t6_new_acks", acks, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
